dmem_responder: RTL and testbench

// - Target end of the core's data-memory bus: answers loads and stores issued by the MEM stage.
// - Holds a byte-enabled word RAM plus a small MMIO block: a 64-bit cycle counter, a scratch register
//   and a TOHOST halt register for test termination.
// - Sits outside the core, beside instruction memory, in the SoC top.
// - Flags illegal accesses through a sticky fault status.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/sram_byteen.sv | 31 +++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, region type and byte-enable legality helper for the data-memory responder.
package dmem_pkg;

    localparam logic [3:0] MMIO_CYCLE_LO = 4'h0;
    localparam logic [3:0] MMIO_CYCLE_HI = 4'h4;
    localparam logic [3:0] MMIO_TOHOST   = 4'h8;
    localparam logic [3:0] MMIO_SCRATCH  = 4'hC;

    localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h1000_0000;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_RAM,
        REG_MMIO
    } region_t;

    // Naturally aligned byte, halfword and word masks only.
    function automatic logic byteen_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_byteen.sv
// Word RAM with combinational read and byte-lane write at the rising edge.
module sram_byteen #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4096,
    parameter string       INIT_FILE = ""
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [WIDTH/8-1:0]       i_be,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < NB; k++) begin
                if (i_be[k]) begin
                    mem_q[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus target: byte-enabled RAM plus MMIO cycle counter, scratch and TOHOST halt,
// with a sticky fault flag for unmapped or misshaped accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter string       INIT_FILE = ""
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [3:0]       i_byteen,
    input  logic             i_write_enable,
    input  logic             i_read_enable,
    output logic [WIDTH-1:0] o_read_data,
    output logic             o_halt,
    output logic [WIDTH-1:0] o_tohost_value,
    output logic             o_fault,
    output logic [WIDTH-1:0] o_fault_addr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NB = 4;

    logic             halt_q,       halt_d;
    logic [WIDTH-1:0] tohost_q,     tohost_d;
    logic             fault_q,      fault_d;
    logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic [63:0]      cycle_q,      cycle_d;
    logic [WIDTH-1:0] hi_shadow_q,  hi_shadow_d;
    logic [WIDTH-1:0] scratch_q,    scratch_d;

    region_t          region;
    logic             be_bad;
    logic             fault_now;
    logic             rd_ok;
    logic             wr_ok;
    logic [3:0]       mmio_off;
    logic [WIDTH-1:0] mmio_rdata;
    logic [WIDTH-1:0] ram_rdata;
    logic             ram_we;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^i_addr[1:0];

    // RAM base is DEPTH*4 aligned, so an upper-bit match is the range check.
    always_comb begin
        region = REG_NONE;
        if (i_addr[WIDTH-1:AW+2] == RAM_BASE[WIDTH-1:AW+2]) begin
            region = REG_RAM;
        end else if (i_addr[WIDTH-1:4] == MMIO_BASE[WIDTH-1:4]) begin
            region = REG_MMIO;
        end
    end

    assign be_bad    = (i_byteen != 4'b0000) && !byteen_legal(i_byteen);
    assign fault_now = (i_read_enable || i_write_enable) && ((region == REG_NONE) || be_bad);
    assign rd_ok     = i_read_enable && !fault_now;
    assign wr_ok     = i_write_enable && !fault_now && !halt_q && i_reset_n
                       && (i_byteen != 4'b0000);
    assign mmio_off  = {i_addr[3:2], 2'b00};
    assign ram_we    = wr_ok && (region == REG_RAM);

    sram_byteen #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_be    (i_byteen),
        .i_addr  (i_addr[AW+1:2]),
        .i_wdata (i_write_data),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        mmio_rdata = '0;
        case (mmio_off)
            MMIO_CYCLE_LO: mmio_rdata = cycle_q[31:0];
            MMIO_CYCLE_HI: mmio_rdata = hi_shadow_q;
            MMIO_TOHOST:   mmio_rdata = tohost_q;
            MMIO_SCRATCH:  mmio_rdata = scratch_q;
            default:       mmio_rdata = '0;
        endcase
    end

    // Zero-latency read; faulting or idle reads return zero.
    always_comb begin
        o_read_data = '0;
        if (rd_ok) begin
            case (region)
                REG_RAM:  o_read_data = ram_rdata;
                REG_MMIO: o_read_data = mmio_rdata;
                default:  o_read_data = '0;
            endcase
        end
    end

    always_comb begin
        halt_d       = halt_q;
        tohost_d     = tohost_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        cycle_d      = cycle_q;
        hi_shadow_d  = hi_shadow_q;
        scratch_d    = scratch_q;

        if (!halt_q) begin
            cycle_d = cycle_q + 64'd1;
        end

        if (fault_now && !fault_q) begin
            fault_d      = 1'b1;
            fault_addr_d = i_addr;
        end

        // Latching the high half on a LO read gives software a tear-free 64-bit snapshot.
        if (rd_ok && (region == REG_MMIO) && (mmio_off == MMIO_CYCLE_LO)) begin
            hi_shadow_d = cycle_q[63:32];
        end

        if (wr_ok && (region == REG_MMIO)) begin
            case (mmio_off)
                MMIO_TOHOST: begin
                    if ((i_byteen == 4'b1111) && (i_write_data != '0)) begin
                        halt_d   = 1'b1;
                        tohost_d = i_write_data;
                    end
                end
                MMIO_SCRATCH: begin
                    for (int k = 0; k < NB; k++) begin
                        if (i_byteen[k]) begin
                            scratch_d[8*k +: 8] = i_write_data[8*k +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            halt_q       <= 1'b0;
            tohost_q     <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cycle_q      <= '0;
            hi_shadow_q  <= '0;
            scratch_q    <= '0;
        end else begin
            halt_q       <= halt_d;
            tohost_q     <= tohost_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cycle_q      <= cycle_d;
            hi_shadow_q  <= hi_shadow_d;
            scratch_q    <= scratch_d;
        end
    end

    assign o_halt         = halt_q;
    assign o_tohost_value = tohost_q;
    assign o_fault        = fault_q;
    assign o_fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-level behavioural model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        halt;
    logic [31:0] tohost;
    logic        fault;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    dmem_responder dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_addr         (addr),
        .i_write_data   (wdata),
        .i_byteen       (be),
        .i_write_enable (we),
        .i_read_enable  (re),
        .o_read_data    (rdata),
        .o_halt         (halt),
        .o_tohost_value (tohost),
        .o_fault        (fault),
        .o_fault_addr   (fault_addr)
    );

    // Reference state
    logic [31:0] ram_m [4096];
    logic [63:0] cyc_m;
    logic [31:0] shadow_m, scratch_m, tohost_m, faddr_m;
    logic        halt_m, fault_m;

    int          passed = 0;
    int          failed = 0;
    logic [31:0] last_rd;

    function automatic logic is_ram(input logic [31:0] a);
        return a < 32'h0000_4000;
    endfunction

    function automatic logic is_mmio(input logic [31:0] a);
        return (a >= 32'h1000_0000) && (a < 32'h1000_0010);
    endfunction

    function automatic logic be_illegal(input logic [3:0] b);
        return (b != 4'b0000) && !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                             4'b0011, 4'b1100, 4'b1111});
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] b);
        if (!(is_ram(a) || is_mmio(a)) || be_illegal(b)) return 32'h0;
        if (is_ram(a)) return ram_m[a[13:2]];
        case (a[3:2])
            2'd0:    return cyc_m[31:0];
            2'd1:    return shadow_m;
            2'd2:    return tohost_m;
            default: return scratch_m;
        endcase
    endfunction

    task automatic model_step(input logic rn, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic flt;
        logic halt_next;
        if (!rn) begin
            halt_m = 1'b0; tohost_m = 32'h0; fault_m = 1'b0; faddr_m = 32'h0;
            cyc_m = 64'h0; shadow_m = 32'h0; scratch_m = 32'h0;
            return;
        end
        flt       = (w || r) && (!(is_ram(a) || is_mmio(a)) || be_illegal(b));
        halt_next = halt_m;
        if (flt && !fault_m) begin
            fault_m = 1'b1;
            faddr_m = a;
        end
        if (r && !flt && is_mmio(a) && (a[3:2] == 2'd0)) shadow_m = cyc_m[63:32];
        if (w && !flt && !halt_m) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k] && is_ram(a)) ram_m[a[13:2]][8*k +: 8] = d[8*k +: 8];
                if (b[k] && is_mmio(a) && (a[3:2] == 2'd3)) scratch_m[8*k +: 8] = d[8*k +: 8];
            end
            if (is_mmio(a) && (a[3:2] == 2'd2) && (b == 4'b1111) && (d != 32'h0)) begin
                halt_next = 1'b1;
                tohost_m  = d;
            end
        end
        if (!halt_m) cyc_m = cyc_m + 64'd1;
        halt_m = halt_next;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after the previous edge, check read data, then registered state.
    task automatic step(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input string tag);
        logic [31:0] exp_rd;
        we = w; re = r; addr = a; wdata = d; be = b;
        #1;
        exp_rd  = r ? model_read(a, b) : 32'h0;
        last_rd = rdata;
        check({tag, ":rdata"}, 64'(rdata), 64'(exp_rd));
        @(posedge clk);
        model_step(rst_n, w, r, a, d, b);
        #1;
        check({tag, ":halt"},       64'(halt),       64'(halt_m));
        check({tag, ":tohost"},     64'(tohost),     64'(tohost_m));
        check({tag, ":fault"},      64'(fault),      64'(fault_m));
        check({tag, ":fault_addr"}, 64'(fault_addr), 64'(faddr_m));
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, tag);
    endtask

    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rb;
    logic        rw, rr;
    int unsigned sel;

    initial begin
        rst_n = 1'b0;
        we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'b0000;

        repeat (3) idle("reset");
        rst_n = 1'b1;
        repeat (9) idle("count");
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "cycle9");
        check("cycle9_const", 64'(last_rd), 64'd9);

        step(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, "sw100");
        step(1'b1, 1'b0, 32'h0000_0101, 32'h0000_5500, 4'b0010, "sb101");
        step(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b1111, "lw100");
        check("merge_const", 64'(last_rd), 64'hDEAD_55EF);

        step(1'b1, 1'b0, 32'h0000_0200, 32'h2222_2222, 4'b1111, "sw200");
        step(1'b1, 1'b1, 32'h0000_0200, 32'h1111_1111, 4'b1111, "rdw200");
        check("rdw_old_const", 64'(last_rd), 64'h2222_2222);
        step(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b1111, "lw200");
        check("rdw_new_const", 64'(last_rd), 64'h1111_1111);

        step(1'b1, 1'b0, 32'h1000_000C, 32'hA5A5_A5A5, 4'b1111, "scr_w");
        step(1'b1, 1'b0, 32'h1000_000C, 32'h3C00_0000, 4'b1000, "scr_b3");
        step(1'b0, 1'b1, 32'h1000_000C, 32'h0, 4'b1111, "scr_r");
        check("scratch_const", 64'(last_rd), 64'h3CA5_A5A5);
        step(1'b1, 1'b0, 32'h1000_0000, 32'hFFFF_FFFF, 4'b1111, "ro_write");
        step(1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'b1111, "hi_read");

        // Jump the counter near the 32-bit carry.
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle_q;
        cyc_m = 64'h0000_0000_FFFF_FFFE;
        idle("pre_carry");
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "lo_carry");
        check("lo_carry_const", 64'(last_rd), 64'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'b1111, "hi_shadow");
        check("hi_shadow_const", 64'(last_rd), 64'h0);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "lo_again");
        step(1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'b1111, "hi_again");
        check("hi_after_carry_const", 64'(last_rd), 64'h1);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'h300 + 32'(4 * i), $urandom, 4'b1111, "init");
        end
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 12)      ra = 32'h300 + 32'($urandom_range(0, 63));
            else if (sel < 15) ra = 32'h1000_000C;
            else if (sel < 18) ra = 32'h1000_0000 + 32'(4 * $urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 3))
                    0:       ra = 32'h2000_0000 | 32'($urandom_range(0, 65535));
                    1:       ra = 32'h0000_4000;
                    2:       ra = 32'h1000_0010;
                    default: ra = 32'h0FFF_FFFC;
                endcase
            end
            if ($urandom_range(0, 4) == 0) rb = 4'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 6))
                    0: rb = 4'b0001; 1: rb = 4'b0010; 2: rb = 4'b0100; 3: rb = 4'b1000;
                    4: rb = 4'b0011; 5: rb = 4'b1100; default: rb = 4'b1111;
                endcase
            end
            rw = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            if (ra == 32'h1000_0008) rw = 1'b0;
            rd = $urandom;
            step(rw, rr, ra, rd, rb, "rand");
        end

        rst_n = 1'b0;
        step(1'b1, 1'b0, 32'h0000_0100, 32'hBAD0_BAD0, 4'b1111, "rst_write");
        rst_n = 1'b1;
        step(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b1111, "after_rst");
        check("rst_write_dropped", 64'(last_rd), 64'hDEAD_55EF);

        step(1'b0, 1'b1, 32'h2000_0000, 32'h0, 4'b1111, "unmapped");
        check("unmapped_rd_const", 64'(last_rd), 64'h0);
        check("fault_addr_const", 64'(fault_addr), 64'h2000_0000);
        step(1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 4'b0101, "bad_be");
        check("first_fault_kept", 64'(fault_addr), 64'h2000_0000);
        step(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b1111, "bad_be_rd");
        check("bad_be_dropped", 64'(last_rd), 64'hDEAD_55EF);

        step(1'b1, 1'b0, 32'h1000_0008, 32'h0000_0000, 4'b1111, "tohost_zero");
        step(1'b1, 1'b0, 32'h1000_0008, 32'h0000_0001, 4'b1111, "tohost");
        check("halt_const", 64'(halt), 64'h1);
        check("tohost_const", 64'(tohost), 64'h1);
        step(1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_F00D, 4'b1111, "halted_sw");
        step(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b1111, "halted_rd");
        check("halted_ram_const", 64'(last_rd), 64'hDEAD_55EF);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "frozen1");
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "frozen2");
        step(1'b0, 1'b1, 32'h1000_0008, 32'h0, 4'b1111, "tohost_rd");

        rst_n = 1'b0;
        idle("final_rst");
        rst_n = 1'b1;
        check("rst_halt_const", 64'(halt), 64'h0);
        check("rst_fault_const", 64'(fault), 64'h0);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "cyc_restart");
        check("cyc_restart_const", 64'(last_rd), 64'h0);
        step(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'b1111, "retained");
        check("retained_const", 64'(last_rd), 64'hDEAD_55EF);
        step(1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'b1111, "cyc_runs");

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule
